fft_8p_loader: RTL and testbench



---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_8p_loader.sv | 144 ++++++++++++++
 tb/tb_fft_8p_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: types and constants shared by the 8-point FFT front end.
//   FFT_N, FFT_DW  : default frame length and component width
//   cplx_t         : one complex sample (re, im), two's complement
//   frame_t        : one natural-order frame of FFT_N samples
//   loader_state_e : loader FSM states
package fft_pkg;

   localparam int FFT_N  = 8;
   localparam int FFT_DW = 16;

   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   typedef cplx_t frame_t [FFT_N];

   typedef enum logic {
      FILL = 1'b0,
      FIRE = 1'b1
   } loader_state_e;

endpackage

// File: rtl/fft_8p_loader.sv
// fft_8p_loader: serial-to-parallel frame loader in front of the 8-point FFT.
// Collects N complex samples over a valid/ready stream into a natural-order
// frame, then holds the frame with fft_start until the core reports done or
// the wait times out.
//
// Optional build macro: FFT_LOADER_PRESCALE_EN
//   defined   -> each sample is arithmetically shifted right by clog2(N)
//                before it is stored (headroom for the butterfly stages)
//   undefined -> samples are stored unmodified
//
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset
//   s_valid/s_ready        sample handshake
//   s_real, s_imag, s_last sample payload and end-of-frame marker
//   fft_start, fft_done    start (held while frame is valid) / core completion
//   x_real, x_imag         packed frame, slice k = k-th accepted sample
//   frame_err              one-cycle pulse on s_last mismatch
//   timeout_err            one-cycle pulse when the core never completes
//   frame_cnt              completed frames, wraps at 2^16
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | accepting samples into the buffer, s_ready=1
// FIRE  | frame held, fft_start=1, waiting for fft_done or timeout
module fft_8p_loader
   import fft_pkg::*;
#(
   parameter int DATA_WIDTH = FFT_DW,
   parameter int N          = FFT_N,
   parameter int TIMEOUT    = 64
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_real,
   input  logic [DATA_WIDTH-1:0]   s_imag,
   input  logic                    s_last,
   output logic                    fft_start,
   input  logic                    fft_done,
   output logic [N*DATA_WIDTH-1:0] x_real,
   output logic [N*DATA_WIDTH-1:0] x_imag,
   output logic                    frame_err,
   output logic                    timeout_err,
   output logic [15:0]             frame_cnt
);

   localparam int IW = $clog2(N);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
   // Wait timer counts down from TIMEOUT-1 in the first FIRE cycle, so the
   // terminal count is reached in FIRE cycle TIMEOUT.
   localparam logic [TW-1:0] TC_LOAD  = TW'(TIMEOUT - 1);
   // fft_done is honoured from the third FIRE cycle on; the core needs start
   // held across its two input register stages.
   localparam logic [TW-1:0] DONE_OK  = TW'(TIMEOUT - 3);

   loader_state_e state, state_nxt;

   logic                  run_q;
   logic [IW-1:0]         idx;
   logic [TW-1:0]         wait_cnt;
   logic [DATA_WIDTH-1:0] buf_re [N];
   logic [DATA_WIDTH-1:0] buf_im [N];
   logic [DATA_WIDTH-1:0] d_re, d_im;
   logic                  accept, at_last, done_ok, tc_hit;

   // run_q keeps s_ready low while reset is applied and for the first edge after.
   assign s_ready   = run_q && (state == FILL);
   assign accept    = s_valid && s_ready;
   assign at_last   = (idx == IDX_LAST);
   assign fft_start = (state == FIRE);
   assign done_ok   = fft_done && (wait_cnt <= DONE_OK);
   assign tc_hit    = (wait_cnt == '0);

`ifdef FFT_LOADER_PRESCALE_EN
   assign d_re = $signed(s_real) >>> IW;
   assign d_im = $signed(s_imag) >>> IW;
`else
   assign d_re = s_real;
   assign d_im = s_imag;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && at_last && s_last) state_nxt = FIRE;
         FIRE:    if (done_ok || tc_hit)           state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= FILL;
         run_q       <= 1'b0;
         idx         <= '0;
         wait_cnt    <= TC_LOAD;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nxt;
         run_q       <= 1'b1;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         if (accept) begin
            // s_last must coincide with the N-th sample; otherwise restart.
            if (at_last != s_last) begin
               frame_err <= 1'b1;
               idx       <= '0;
            end else begin
               idx <= idx + IW'(1);   // wraps to 0 after the last slot
            end
         end
         if (state == FIRE) begin
            wait_cnt <= wait_cnt - TW'(1);
            if (done_ok)     frame_cnt   <= frame_cnt + 16'd1;
            else if (tc_hit) timeout_err <= 1'b1;
         end else begin
            wait_cnt <= TC_LOAD;
         end
      end
   end

   // Writes happen only on accept, which requires FILL; the frame is frozen in FIRE.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < N; k++) begin
            buf_re[k] <= '0;
            buf_im[k] <= '0;
         end
      end else if (accept) begin
         buf_re[idx] <= d_re;
         buf_im[idx] <= d_im;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_pack
      assign x_real[k*DATA_WIDTH +: DATA_WIDTH] = buf_re[k];
      assign x_imag[k*DATA_WIDTH +: DATA_WIDTH] = buf_im[k];
   end

endmodule

// File: tb/tb_fft_8p_loader.sv
// tb_fft_8p_loader: self-checking bench for fft_8p_loader.
// Table of frame scenarios (optional framing error, clean frame, FIRE exit
// cycle) plus hand sequences for FIRE-time stimulus and mid-frame reset.
// Honours FFT_LOADER_PRESCALE_EN in its reference model.
module tb_fft_8p_loader;

   localparam int DW = 16;
   localparam int NP = 8;

   logic           clk = 1'b0;
   logic           arst_n = 1'b0;
   logic           s_valid = 1'b0;
   logic           s_last = 1'b0;
   logic           fft_done = 1'b0;
   logic [DW-1:0]  s_real = '0;
   logic [DW-1:0]  s_imag = '0;
   logic           s_ready, fft_start, frame_err, timeout_err;
   logic [NP*DW-1:0] x_real, x_imag;
   logic [15:0]    frame_cnt;

   int             n_chk = 0;
   int             n_fail = 0;
   logic [15:0]    exp_cnt = '0;

   typedef struct packed {
      logic [NP*DW-1:0] re;
      logic [NP*DW-1:0] im;
   } frm_t;
   frm_t sb_q[$];

   typedef struct {
      logic [DW-1:0] re0;
      logic [DW-1:0] im0;
      logic          im_var;
      int            err_pos;   // 0 none, 1..7 early s_last, 8 missing s_last
      int            done_cyc;  // FIRE cycle carrying fft_done, 0 = never
      int            exp_len;
      logic          exp_tmo;
      int            exp_inc;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   fft_8p_loader dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_real      (s_real),
      .s_imag      (s_imag),
      .s_last      (s_last),
      .fft_start   (fft_start),
      .fft_done    (fft_done),
      .x_real      (x_real),
      .x_imag      (x_imag),
      .frame_err   (frame_err),
      .timeout_err (timeout_err),
      .frame_cnt   (frame_cnt)
   );

   function automatic logic [DW-1:0] model_store(input logic [DW-1:0] v);
`ifdef FFT_LOADER_PRESCALE_EN
      return {{3{v[DW-1]}}, v[DW-1:3]};
`else
      return v;
`endif
   endfunction

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_f(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
      int t;
      t = 0;
      s_valid = 1'b1;
      s_real  = re;
      s_imag  = im;
      s_last  = last;
      while (!s_ready && t < 200) begin
         step();
         t++;
      end
      if (!s_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL beat_ready_wait: s_ready got 0 expected 1 after %0d cycles", t);
      end
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic err_prefix(input int pos);
      for (int k = 0; k < pos; k++)
         beat(16'hE000 + 16'(k), 16'h1000 + 16'(k), (pos < NP) && (k == pos - 1));
      chk_b("frame_err_pulse", frame_err, 1'b1);
      chk_b("no_fire_on_err", fft_start, 1'b0);
   endtask

   task automatic send_clean(input logic [DW-1:0] re0, input logic [DW-1:0] im0,
                             input logic im_var, input logic noise, output frm_t fexp);
      frm_t f, got;
      logic [DW-1:0] re, im;
      for (int k = 0; k < NP; k++) begin
         re = re0 + 16'(k);
         im = im_var ? im0 - 16'(k) : im0;
         f.re[k*DW +: DW] = model_store(re);
         f.im[k*DW +: DW] = model_store(im);
         fft_done = noise && (k < NP - 1);
         beat(re, im, k == NP - 1);
         chk_b("frame_err_clean", frame_err, 1'b0);
      end
      fft_done = 1'b0;
      sb_q.push_back(f);
      chk_b("fire_after_last", fft_start, 1'b1);
      chk_b("ready_low_in_fire", s_ready, 1'b0);
      chk_w("cnt_before_done", 32'(frame_cnt), 32'(exp_cnt));
      got = sb_q.pop_front();
      fexp = got;
      chk_f("frame_real", x_real, got.re);
      chk_f("frame_imag", x_imag, got.im);
   endtask

   task automatic run_fire(input int d, output int len);
      len = 0;
      while (fft_start && len < 200) begin
         len++;
         fft_done = (len == d);
         step();
         fft_done = 1'b0;
      end
   endtask

   initial begin
      frm_t f;
      int   len;

      //           re0       im0     var  err done len tmo inc
      vecs[0] = '{16'h0001, 16'h0000, 1'b0, 0, 3,  3,  1'b0, 1};
      vecs[1] = '{16'h0100, 16'hFFF8, 1'b1, 5, 3,  3,  1'b0, 1};
      vecs[2] = '{16'h8000, 16'h7FF0, 1'b1, 0, 0,  64, 1'b1, 0};
      vecs[3] = '{16'h1234, 16'h0042, 1'b1, 8, 64, 64, 1'b0, 1};
      vecs[4] = '{16'h7FF8, 16'h8001, 1'b1, 1, 1,  64, 1'b1, 0};
      vecs[5] = '{16'hFFF0, 16'h0000, 1'b1, 0, 2,  64, 1'b1, 0};
      vecs[6] = '{16'h4000, 16'hC000, 1'b1, 7, 10, 10, 1'b0, 1};

      // reset state
      step();
      step();
      chk_b("rst_ready", s_ready, 1'b0);
      chk_b("rst_start", fft_start, 1'b0);
      chk_b("rst_ferr", frame_err, 1'b0);
      chk_b("rst_terr", timeout_err, 1'b0);
      chk_w("rst_cnt", 32'(frame_cnt), 32'd0);
      chk_f("rst_xr", x_real, '0);
      arst_n = 1'b1;
      step();
      chk_b("ready_after_rst", s_ready, 1'b1);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].err_pos != 0) err_prefix(vecs[i].err_pos);
         send_clean(vecs[i].re0, vecs[i].im0, vecs[i].im_var, 1'b0, f);
         run_fire(vecs[i].done_cyc, len);
         chk_w("fire_len", 32'(len), 32'(vecs[i].exp_len));
         chk_b("timeout_err", timeout_err, vecs[i].exp_tmo);
         exp_cnt = exp_cnt + 16'(vecs[i].exp_inc);
         chk_w("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
         chk_b("start_low_after", fft_start, 1'b0);
         chk_b("ready_after_fire", s_ready, 1'b1);
         step();
         chk_b("timeout_one_cycle", timeout_err, 1'b0);
         chk_b("ready_next", s_ready, 1'b1);
      end

      // s_valid toggling during FIRE must not disturb the held frame
      send_clean(16'h0A00, 16'h0B00, 1'b1, 1'b0, f);
      s_valid = 1'b1;
      s_real  = 16'hDEAD;
      s_imag  = 16'hBEEF;
      step();
      chk_b("fire_ready_c2", s_ready, 1'b0);
      chk_f("fire_hold_c2", x_real, f.re);
      s_valid = 1'b0;
      step();
      chk_b("fire_ready_c3", s_ready, 1'b0);
      s_valid  = 1'b1;
      fft_done = 1'b1;
      step();
      s_valid  = 1'b0;
      fft_done = 1'b0;
      chk_f("fire_hold_re", x_real, f.re);
      chk_f("fire_hold_im", x_imag, f.im);
      chk_b("fire_exit", fft_start, 1'b0);
      exp_cnt = exp_cnt + 16'd1;
      chk_w("fire_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // reset mid-FILL at idx=4
      for (int k = 0; k < 4; k++) beat(16'h1111 + 16'(k), 16'h2222, 1'b0);
      #2;
      arst_n = 1'b0;
      #1;
      chk_b("mid_rst_ready", s_ready, 1'b0);
      chk_b("mid_rst_start", fft_start, 1'b0);
      chk_b("mid_rst_ferr", frame_err, 1'b0);
      chk_b("mid_rst_terr", timeout_err, 1'b0);
      chk_w("mid_rst_cnt", 32'(frame_cnt), 32'd0);
      chk_f("mid_rst_xr", x_real, '0);
      chk_f("mid_rst_xi", x_imag, '0);
      exp_cnt = '0;
      step();
      chk_b("held_rst_ready", s_ready, 1'b0);
      arst_n = 1'b1;
      step();
      chk_b("rst_release_ready", s_ready, 1'b1);

      // fresh frame after reset, fft_done noise while filling, extreme values
      send_clean(16'h8000, 16'h0010, 1'b0, 1'b1, f);
`ifdef FFT_LOADER_PRESCALE_EN
      chk_w("prescale_re", 32'(x_real[DW-1:0]), 32'h0000F000);
      chk_w("prescale_im", 32'(x_imag[DW-1:0]), 32'h00000002);
`endif
      run_fire(3, len);
      chk_w("post_rst_len", 32'(len), 32'd3);
      exp_cnt = exp_cnt + 16'd1;
      chk_w("post_rst_cnt", 32'(frame_cnt), 32'(exp_cnt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
